// File: rtl/iob_timer_ctrl.sv
// Period timer sequencing an external loadable up-counter: one-shot or periodic
// tick generation with sticky interrupt and a saturating tick tally.
module iob_timer_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TICKS_W = 8
) (
    input  logic               clk_i,
    input  logic               arst_n_i,
    input  logic               ce_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               mode_i,
    input  logic [DATA_W-1:0]  period_i,
    input  logic               irq_ack_i,
    input  logic [DATA_W-1:0]  cnt_i,
    output logic               cnt_en_o,
    output logic               cnt_ld_o,
    output logic [DATA_W-1:0]  cnt_ld_val_o,
    output logic               busy_o,
    output logic               tick_o,
    output logic               irq_o,
    output logic [TICKS_W-1:0] ticks_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    localparam logic [TICKS_W-1:0] TICKS_MAX = '1;
    localparam logic [DATA_W-1:0]  ONE       = DATA_W'(1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   per_q, per_d;
    logic                mode_q, mode_d;
    logic                irq_q, irq_d;
    logic [TICKS_W-1:0]  ticks_q, ticks_d;
    logic                terminal;
    logic                tick;

    assign terminal = (cnt_i == (per_q - ONE));

    // A stop in the same cycle as the terminal count suppresses the tick.
    assign tick = ce_i && (state_q == S_RUN) && terminal && !stop_i;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ce_i) begin
            unique case (state_q)
                S_IDLE: if (start_i) state_d = S_LOAD;
                S_LOAD: state_d = stop_i ? S_IDLE : S_RUN;
                S_RUN: begin
                    if (stop_i) begin
                        state_d = S_IDLE;
                    end else if (terminal && !mode_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o       = (state_q != S_IDLE);
        cnt_en_o     = ce_i && (state_q != S_IDLE);
        cnt_ld_o     = ce_i && ((state_q == S_LOAD) || (tick && mode_q));
        cnt_ld_val_o = '0;
        tick_o       = tick;
        irq_o        = irq_q;
        ticks_o      = ticks_q;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            per_q   <= '0;
            mode_q  <= 1'b0;
            irq_q   <= 1'b0;
            ticks_q <= '0;
        end else begin
            per_q   <= per_d;
            mode_q  <= mode_d;
            irq_q   <= irq_d;
            ticks_q <= ticks_d;
        end
    end

    always_comb begin
        per_d   = per_q;
        mode_d  = mode_q;
        irq_d   = irq_q;
        ticks_d = ticks_q;
        if (ce_i) begin
            if ((state_q == S_IDLE) && start_i) begin
                per_d   = (period_i == '0) ? ONE : period_i;
                mode_d  = mode_i;
                ticks_d = '0;
            end
            if (tick && (ticks_q != TICKS_MAX)) begin
                ticks_d = ticks_q + 1'b1;
            end
            if (tick) begin
                irq_d = 1'b1;
            end else if (irq_ack_i) begin
                irq_d = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iob_timer_ctrl.sv
// Self-checking bench: cycle-position model of the timer plus directed literal scenarios.
module tb_iob_timer_ctrl;

    localparam int DW   = 8;
    localparam int TW   = 2;
    localparam int TMAX = (1 << TW) - 1;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          ce     = 1'b1;
    logic          start  = 1'b0;
    logic          stop   = 1'b0;
    logic          mode   = 1'b0;
    logic          ack    = 1'b0;
    logic [DW-1:0] period = '0;
    logic [DW-1:0] cnt    = '0;
    logic          cnt_en, cnt_ld, busy, tick, irq;
    logic [DW-1:0] ld_val;
    logic [TW-1:0] ticks;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    iob_timer_ctrl #(.DATA_W(DW), .TICKS_W(TW)) dut (
        .clk_i        (clk),
        .arst_n_i     (rst_n),
        .ce_i         (ce),
        .start_i      (start),
        .stop_i       (stop),
        .mode_i       (mode),
        .period_i     (period),
        .irq_ack_i    (ack),
        .cnt_i        (cnt),
        .cnt_en_o     (cnt_en),
        .cnt_ld_o     (cnt_ld),
        .cnt_ld_val_o (ld_val),
        .busy_o       (busy),
        .tick_o       (tick),
        .irq_o        (irq),
        .ticks_o      (ticks)
    );

    // Downstream loadable up-counter
    always @(posedge clk) begin
        if (cnt_ld) cnt <= ld_val;
        else if (cnt_en) cnt <= cnt + 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: busy/loading flags and position within the current period.
    bit m_busy = 0, m_load = 0, m_periodic = 0, m_irq = 0, m_t = 0;
    int m_pos = 0, m_per = 0, m_ticks = 0;

    function automatic bit m_term();
        return ce && m_busy && !m_load && !stop && (m_pos == m_per - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_load = 0; m_periodic = 0; m_irq = 0;
            m_pos = 0; m_per = 0; m_ticks = 0;
        end else if (ce) begin
            m_t = m_term();
            if (m_t) begin
                m_irq = 1;
                m_ticks = (m_ticks >= TMAX) ? TMAX : m_ticks + 1;
            end else if (ack) begin
                m_irq = 0;
            end
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_load = 1; m_periodic = mode; m_ticks = 0;
                    m_per = (period == 0) ? 1 : int'(period);
                end
            end else if (stop) begin
                m_busy = 0;
            end else if (m_load) begin
                m_load = 0; m_pos = 0;
            end else if (m_t) begin
                m_pos = 0;
                if (!m_periodic) m_busy = 0;
            end else begin
                m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_en", cnt_en, 0);
            chk("rst_ld", cnt_ld, 0);
            chk("rst_tick", tick, 0);
            chk("rst_irq", irq, 0);
            chk("rst_ticks", ticks, 0);
        end else begin
            chk("tick", tick, m_term());
            chk("cnt_en", cnt_en, ce && m_busy);
            chk("cnt_ld", cnt_ld, ce && m_busy && (m_load || (m_term() && m_periodic)));
            chk("busy", busy, m_busy);
            chk("irq", irq, m_irq);
            chk("ticks", ticks, m_ticks);
            chk("ld_val", ld_val, 0);
            if (m_busy && !m_load) chk("cnt", cnt, m_pos);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ce = 1; start = 0; stop = 0; ack = 0; mode = 0; period = '0;
        rst_n = 0;
        next();
        next();
        rst_n = 1;
    endtask

    // One-shot period 5 from cycle 0, with optional ce=0 gap starting at cycle gs.
    task automatic oneshot(input int gs, output int tick_cyc, output int busy_cnt);
        do_reset();
        start = 1; period = 8'd5; mode = 0;
        tick_cyc = -1; busy_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            #3;
            if (tick && tick_cyc < 0) tick_cyc = c;
            if (busy) busy_cnt++;
            next();
            start = 0;
            ce = !((c + 1 >= gs) && (c + 1 < gs + 4));
        end
        ce = 1;
    endtask

    int tc, bc, nt, nc;

    initial begin
        next();
        chk("reset_busy", busy, 0);
        chk("reset_ticks", ticks, 0);

        oneshot(100, tc, bc);
        chk("oneshot_tick_cycle", tc, 6);
        chk("oneshot_busy_cycles", bc, 6);
        chk("oneshot_ticks", ticks, 1);
        chk("oneshot_irq", irq, 1);

        oneshot(3, tc, bc);
        chk("ce_gap_tick_cycle", tc, 10);
        chk("ce_gap_busy_cycles", bc, 10);

        // Periodic, period 3, 10 RUN cycles
        do_reset();
        start = 1; period = 8'd3; mode = 1;
        next(); start = 0;
        next();
        nt = 0; nc = 0;
        for (int i = 0; i < 10; i++) begin
            #3;
            if (tick) nt++;
            if (tick == cnt_ld) nc++;
            next();
        end
        chk("periodic_tick_count", nt, 3);
        chk("periodic_ld_coincident", nc, 10);
        chk("periodic_ticks", ticks, 3);
        stop = 1; next(); stop = 0;
        chk("periodic_stop_busy", busy, 0);

        // Period 0 and 1: tick every RUN cycle, tally saturates
        for (int p = 0; p < 2; p++) begin
            do_reset();
            start = 1; period = DW'(p); mode = 1;
            next(); start = 0;
            next();
            nt = 0;
            for (int i = 0; i < 5; i++) begin
                #3;
                if (tick) nt++;
                next();
            end
            chk("short_period_ticks", nt, 5);
            chk("ticks_saturate", ticks, 3);
        end

        // stop coincident with terminal
        do_reset();
        start = 1; period = 8'd3; mode = 0;
        next(); start = 0;
        next(); next(); next();
        stop = 1;
        #3 chk("stop_term_tick", tick, 0);
        next(); stop = 0;
        chk("stop_term_busy", busy, 0);
        chk("stop_term_irq", irq, 0);
        chk("stop_term_ticks", ticks, 0);

        // irq ack collision, then lone ack
        do_reset();
        start = 1; period = 8'd2; mode = 0;
        next(); start = 0;
        next(); next();
        ack = 1;
        #3 chk("ack_coll_tick", tick, 1);
        next(); ack = 0;
        chk("ack_coll_irq", irq, 1);
        next(); ack = 1;
        next(); ack = 0;
        chk("lone_ack_irq", irq, 0);

        // Reset mid-RUN
        do_reset();
        start = 1; period = 8'd5; mode = 1;
        next(); start = 0;
        next(); next(); next();
        rst_n = 0;
        #1;
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_en", cnt_en, 0);
        chk("midrun_rst_ld", cnt_ld, 0);
        chk("midrun_rst_tick", tick, 0);
        next(); rst_n = 1;

        // start while busy must not relatch period
        do_reset();
        start = 1; period = 8'd4; mode = 0;
        next(); start = 0;
        next(); start = 1; period = 8'd2;
        tc = -1;
        for (int c = 2; c < 9; c++) begin
            #3;
            if (tick && tc < 0) tc = c;
            next();
            if (c >= 5) start = 0;
        end
        chk("busy_start_tick_cycle", tc, 5);

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n  = ($urandom_range(0, 199) != 0);
            ce     = ($urandom_range(0, 7) != 0);
            start  = ($urandom_range(0, 2) == 0);
            stop   = ($urandom_range(0, 15) == 0);
            mode   = $urandom_range(0, 1) == 1;
            period = DW'($urandom_range(0, 6));
            ack    = ($urandom_range(0, 5) == 0);
            next();
        end
        rst_n = 1;
        next();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
